// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg
//   Shared constants for the RAM DMA initiator: FSM state encoding,
//   command direction values and the read-ahead FIFO depth.
package ram_dma_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    // cmd_dir values
    localparam logic DIR_READ  = 1'b0;  // RAM -> out stream
    localparam logic DIR_WRITE = 1'b1;  // in stream -> RAM

    // Read-ahead FIFO depth; also the credit limit for outstanding reads.
    // Must be a power of two (FIFO pointers wrap naturally).
    localparam int RD_FIFO_DEPTH = 4;

endpackage

// File: rtl/ram_dma_fifo.sv
// ram_dma_fifo
//   Small synchronous FIFO holding read words (data + last flag) between
//   the RAM read pipeline and the out stream. Show-ahead: the head entry is
//   visible on head_data/head_last without a pop.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   push, push_data,
//   push_last             write one entry (caller guarantees not full)
//   pop                   drop the head entry (caller guarantees not empty)
//   head_data, head_last  current head entry
//   count                 number of entries held, 0..DEPTH
module ram_dma_fifo
    import ram_dma_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = RD_FIFO_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0]  mem_last;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is reset as well, because the head entry
            // drives out_data directly and must read as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
            end
            mem_last <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem_data[rd_ptr];
    assign head_last = mem_last[rd_ptr];

endmodule

// File: rtl/ram_dma.sv
// ram_dma
//   Command-driven DMA initiator on a single-port RAM with 1-cycle read
//   latency. A read command streams len words from RAM onto out_*; a write
//   command stores len words taken from in_*. Addresses wrap mod 2^ADDR_W.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_dir, cmd_base, cmd_len      direction (0 read, 1 write), first
//                                   index, word count 0..2^ADDR_W
//   ram_addr, ram_wr_data, ram_we   registered RAM request
//   ram_rd_data                     RAM data, one cycle after ram_addr
//   out_valid/out_ready, out_data,
//   out_last                        read stream
//   in_valid/in_ready, in_data      write stream
//   busy                            command in progress
//   done                            one-cycle completion pulse
module ram_dma
    import ram_dma_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    output logic [31:0]       ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done
);

    localparam int              CNT_W    = $clog2(RD_FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FIFO_CAP = CNT_W'(RD_FIFO_DEPTH);
    localparam logic [ADDR_W:0]  LEN_ONE  = (ADDR_W + 1)'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    // Words issued (RD) or accepted (WR) so far in the current command.
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W-1:0] addr_q;

    // Read pipeline: stage 1 = address on ram_addr this cycle,
    // stage 2 = ram_rd_data valid this cycle. *_last marks word len-1.
    logic iss1, last1;
    logic iss2, last2;

    // Final write accepted; done follows the last ram_we cycle.
    logic wr_fin;

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  occupancy;
    logic              fifo_head_last;
    logic              can_issue;
    logic              pop;
    logic              rd_done;
    logic              in_hs;
    logic              is_final;
    logic [ADDR_W-1:0] next_addr;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign ram_addr  = {{(32 - ADDR_W){1'b0}}, addr_q};

    // Credit check: buffered words plus reads still in the RAM pipeline
    // must leave a free FIFO slot, so a returned word always has room.
    assign occupancy = fifo_count + CNT_W'(iss1) + CNT_W'(iss2);
    assign can_issue = (state == ST_RD) && (occupancy < FIFO_CAP) && (cnt_q < len_q);

    assign next_addr = base_q + cnt_q[ADDR_W-1:0];
    assign is_final  = (cnt_q == len_q - LEN_ONE);

    assign out_valid = (fifo_count != '0);
    assign out_last  = out_valid && fifo_head_last;
    assign pop       = out_valid && out_ready;
    assign rd_done   = (state == ST_RD) && pop && fifo_head_last;

    assign in_ready  = (state == ST_WR) && (cnt_q < len_q);
    assign in_hs     = in_valid && in_ready;

    ram_dma_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RD_FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (iss2),
        .push_data (ram_rd_data),
        .push_last (last2),
        .pop       (pop),
        .head_data (out_data),
        .head_last (fifo_head_last),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            ram_wr_data <= '0;
            ram_we      <= 1'b0;
            iss1        <= 1'b0;
            last1       <= 1'b0;
            iss2        <= 1'b0;
            last2       <= 1'b0;
            wr_fin      <= 1'b0;
            done        <= 1'b0;
        end else begin
            // Single-cycle pulses and pipeline advance by default.
            ram_we <= 1'b0;
            wr_fin <= 1'b0;
            done   <= wr_fin;
            iss1   <= 1'b0;
            last1  <= 1'b0;
            iss2   <= iss1;
            last2  <= last1;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        base_q <= cmd_base;
                        len_q  <= cmd_len;
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            case (cmd_dir)
                                DIR_READ: begin
                                    // First read issues on the handshake edge.
                                    state  <= ST_RD;
                                    addr_q <= cmd_base;
                                    iss1   <= 1'b1;
                                    last1  <= (cmd_len == LEN_ONE);
                                    cnt_q  <= LEN_ONE;
                                end
                                DIR_WRITE: begin
                                    state <= ST_WR;
                                    cnt_q <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                ST_RD: begin
                    if (can_issue) begin
                        addr_q <= next_addr;
                        iss1   <= 1'b1;
                        last1  <= is_final;
                        cnt_q  <= cnt_q + LEN_ONE;
                    end
                    if (rd_done) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end

                ST_WR: begin
                    if (in_hs) begin
                        ram_we      <= 1'b1;
                        addr_q      <= next_addr;
                        ram_wr_data <= in_data;
                        cnt_q       <= cnt_q + LEN_ONE;
                        if (is_final) begin
                            state  <= ST_IDLE;
                            wr_fin <= 1'b1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma
//   Self-checking bench for ram_dma: a behavioural RAM with 1-cycle read
//   latency, a reference memory image updated from the write commands, and
//   directed plus randomized read/write commands.
module tb_ram_dma;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;
    logic [31:0]       ram_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              busy;
    logic              done;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int we_cnt      = 0;
    logic load_pattern;

    logic [DATA_W-1:0] mem     [DEPTH];  // RAM seen by the DUT
    logic [DATA_W-1:0] ref_mem [DEPTH];  // expected RAM contents

    ram_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_dir     (cmd_dir),
        .cmd_base    (cmd_base),
        .cmd_len     (cmd_len),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_we      (ram_we),
        .ram_rd_data (ram_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pattern(input int k);
        case (k % 3)
            0:       return 32'h0000_0001;
            1:       return 32'h0000_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Behavioural single-port RAM, read data one cycle after the address.
    always @(posedge clk) begin
        if (load_pattern) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= pattern(k);
        end else begin
            ram_rd_data <= mem[ram_addr[ADDR_W-1:0]];
            if (ram_we) mem[ram_addr[ADDR_W-1:0]] <= ram_wr_data;
        end
    end

    always @(posedge clk) begin
        if (done)   done_cnt <= done_cnt + 1;
        if (ram_we) we_cnt   <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read command. mode 0: out_ready high; 1: low 10 cycles after the first
    // word then toggling; 2: random. abort_at>0 returns right after that
    // many words have been accepted (caller then resets).
    task automatic run_read(input logic [ADDR_W-1:0] base, input int len, input int mode,
                            input bit timing, input int abort_at);
        int i = 0, rel, first_v = -1, since = 0, ahead, max_ahead = 0, d0, w0;
        logic [DATA_W-1:0] held_d, exp_d;
        logic held_l;
        bit have_held = 0;
        d0 = done_cnt; w0 = we_cnt;
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_base = base; cmd_len = (ADDR_W + 1)'(len);
        @(negedge clk);
        check("rd_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rel = 1;
        while (i < len && rel < 400) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (first_v >= 0 && since > 10) ? ((since % 2) == 1) : 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (timing && rel == 1) check("rd_first_addr", ram_addr, {22'b0, base});
            if (mode == 1) begin
                ahead = ((int'(ram_addr[ADDR_W-1:0]) - int'(base) + DEPTH) % DEPTH) + 1 - i;
                if (ahead > max_ahead) max_ahead = ahead;
            end
            if (out_valid) begin
                if (first_v < 0) first_v = rel;
                if (have_held) begin
                    check("rd_hold_data", out_data, held_d);
                    check("rd_hold_last", out_last, held_l);
                end
                if (out_ready) begin
                    exp_d = ref_mem[(int'(base) + i) % DEPTH];
                    check($sformatf("rd_data[%0d]", i), out_data, exp_d);
                    check($sformatf("rd_last[%0d]", i), out_last, (i == len - 1));
                    if (timing) check($sformatf("rd_beat_cycle[%0d]", i), rel, 3 + i);
                    i++;
                    have_held = 0;
                end else begin
                    held_d = out_data; held_l = out_last; have_held = 1;
                end
            end else if (have_held) begin
                check("rd_valid_held", out_valid, 1);
            end
            if (abort_at > 0 && i == abort_at) return;
            @(posedge clk); #1;
            rel++;
            if (first_v >= 0) since++;
        end
        check("rd_complete", i, len);
        @(negedge clk);
        check("rd_done", done, 1);
        check("rd_idle", cmd_ready, 1);
        check("rd_out_valid_after", out_valid, 0);
        if (mode == 1) check("rd_max_ahead", max_ahead, 4);
        @(posedge clk); #1;
        check("rd_done_count", done_cnt - d0, 1);
        check("rd_no_we", we_cnt - w0, 0);
    endtask

    // Write command. fixed: data A0+i, else random. gaps: random in_valid.
    task automatic run_write(input logic [ADDR_W-1:0] base, input int len, input bit fixed,
                             input bit gaps);
        logic [DATA_W-1:0] w [$];
        logic [DATA_W-1:0] pdata;
        int i = 0, rel = 0, pidx = 0, d0, w0;
        bit pend = 0;
        for (int k = 0; k < len; k++) w.push_back(fixed ? DATA_W'(32'hA0 + k) : $urandom);
        d0 = done_cnt; w0 = we_cnt;
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_base = base; cmd_len = (ADDR_W + 1)'(len);
        @(negedge clk);
        check("wr_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while ((i < len || pend) && rel < 400) begin
            in_valid = (i < len) && (!gaps || $urandom_range(0, 2) != 0);
            in_data  = in_valid ? w[i] : $urandom;
            @(negedge clk);
            if (pend) begin
                check($sformatf("wr_we[%0d]", pidx), ram_we, 1);
                check($sformatf("wr_addr[%0d]", pidx), ram_addr,
                      32'((int'(base) + pidx) % DEPTH));
                check($sformatf("wr_data[%0d]", pidx), ram_wr_data, pdata);
                ref_mem[(int'(base) + pidx) % DEPTH] = pdata;
                pend = 0;
            end else begin
                check("wr_we_idle", ram_we, 0);
            end
            check("wr_in_ready", in_ready, (i < len));
            if (in_valid && in_ready) begin
                pend = 1; pidx = i; pdata = w[i]; i++;
            end
            @(posedge clk); #1;
            rel++;
        end
        in_valid = 1'b0;
        check("wr_complete", i, len);
        @(negedge clk);
        check("wr_done", done, 1);
        check("wr_we_after", ram_we, 0);
        @(posedge clk); #1;
        check("wr_done_count", done_cnt - d0, 1);
        check("wr_we_count", we_cnt - w0, len);
    endtask

    task automatic run_zero(input logic dir);
        int d0, w0;
        d0 = done_cnt; w0 = we_cnt;
        cmd_valid = 1'b1; cmd_dir = dir; cmd_base = ADDR_W'($urandom); cmd_len = '0;
        @(negedge clk);
        check("z_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("z_done", done, 1);
        check("z_cmd_ready_after", cmd_ready, 1);
        check("z_out_valid", out_valid, 0);
        check("z_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("z_we_count", we_cnt - w0, 0);
        check("z_done_count", done_cnt - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n = 1'b0; load_pattern = 1'b1;
        cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_base = '0; cmd_len = '0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = pattern(k);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wr_data", ram_wr_data, 0);
        check("rst_ram_we", ram_we, 0);
        load_pattern = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Pattern read with exact timing
        run_read(10'h000, 9, 0, 1, 0);
        // Backpressure: long stall then toggling ready
        run_read(10'h005, 8, 1, 0, 0);
        // Write across the wrap point, then read it back
        run_write(10'h3FE, 4, 1, 0);
        run_read(10'h3FE, 4, 0, 1, 0);
        // Zero-length commands
        run_zero(1'b0);
        run_zero(1'b1);
        // Bulk write then read-back
        run_write(10'h100, 16, 0, 0);
        run_read(10'h100, 16, 0, 1, 0);
        // Randomized commands against the reference image
        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 1) == 1)
                run_write(ADDR_W'($urandom), $urandom_range(1, 40), 0, 1);
            else
                run_read(ADDR_W'($urandom), $urandom_range(1, 40), 2, 0, 0);
        end

        // Asynchronous abort mid-read, then a fresh read
        out_ready = 1'b1;
        d0 = done_cnt;
        run_read(10'h000, 9, 0, 0, 3);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_out_last", out_last, 0);
        check("abort_busy", busy, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_ram_addr", ram_addr, 0);
        check("abort_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_no_done", done_cnt - d0, 0);
        run_read(10'h000, 2, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_dma.md
# ram_dma

Command-driven DMA initiator for a core-local `ram` port: the master side of the single-port, 1-cycle-read-latency RAM interface (address, write data, write enable, read data). A read command streams `len` words out of the RAM on a valid/ready output toward the NoC. A write command accepts `len` words from a valid/ready input and stores them. One instance sits between each node's RAM and its network interface, moving image chunks and kernels without core involvement.

## Interface
- `ADDR_W`, 10: RAM index width (depth 2^ADDR_W = 1024).
- `DATA_W`, 32: word width.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high exactly when FSM is IDLE.
- `cmd_dir`  in  1  0 = RAM→stream (read), 1 = stream→RAM (write).
- `cmd_base`  in  ADDR_W  first RAM index.
- `cmd_len`  in  ADDR_W+1  word count, 0..1024.
- `ram_addr`  out  32  registered RAM address; bits [31:ADDR_W] always 0.
- `ram_wr_data`  out  DATA_W  registered write data.
- `ram_we`  out  1  registered write enable.
- `ram_rd_data`  in  DATA_W  RAM read data, valid the cycle after `ram_addr` is presented.
- `out_valid`, `out_ready`, `out_data[DATA_W]`, `out_last`  out/in/out/out  read stream.
- `in_valid`, `in_ready`, `in_data[DATA_W]`  in/out/in  write stream.
- `busy`  out  1  FSM not IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RD, WR.
- IDLE: on `cmd_valid && cmd_ready`, latch base, len, dir.
  - len = 0: no RAM access, stay IDLE, `done` high next cycle.
  - dir = 0: go RD; `ram_addr <= cmd_base` in the same edge, so the first issue happens on the handshake.
  - dir = 1: go WR.
- Address of word i is `(base + i) mod 2^ADDR_W`; wrap from 0x3FF to 0x000 is silent.
- RD: a 4-entry read FIFO plus an in-flight counter of up to 2 stages (issue and RAM latch).
  - A new address is issued in a cycle only when `fifo_count + inflight < 4` and `issued < len`.
  - Each `ram_rd_data` sample whose issue flag is set is pushed into the FIFO.
  - FIFO head drives `out_data`, and `out_valid` is high when the FIFO is non-empty.
  - `out_last` is high with the word of index len-1.
  - On the `out_last` handshake, return to IDLE; `done` is high the next cycle.
  - `ram_we` stays 0 throughout RD.
- WR: `in_ready` is high while accepted < len.
  - On each handshake, the next cycle has `ram_we = 1`, `ram_addr = base + i`, `ram_wr_data = in_data`.
  - After the handshake for word len-1, `in_ready` drops, the FSM returns to IDLE, and `done` is high in the cycle after the final `ram_we` cycle.
- IDLE: `ram_we = 0`. `ram_addr` holds its last value, which is harmless because read data is discarded.
- While `out_valid && !out_ready`, `out_data` and `out_last` are held stable.
- `cmd_valid` outside IDLE is ignored.
- Any `rst_n` assertion, including mid-command, aborts immediately. The FIFO is emptied and all state returns to reset values, with no partial completion pulse.
- Reset values: `cmd_ready` 1, `busy` 0, `done` 0, `out_valid` 0, `out_data` 0, `out_last` 0, `in_ready` 0, `ram_addr` 0, `ram_wr_data` 0, `ram_we` 0.

## Timing
- Read: if the command handshake is in cycle 0, then `ram_addr = base` in cycle 1, data is in the FIFO at the end of cycle 2, and the first `out_valid` is in cycle 3.
- With `out_ready` held high, read throughput is 1 word/cycle. A len-N read finishes its last handshake in cycle N+2, and `done` is in cycle N+3.
- Write: `ram_we` follows each input handshake by 1 cycle. Throughput is 1 word/cycle.
- Maximum read-ahead is 4 words. No RAM data word is ever dropped, because a credit is reserved at issue.
- A new command can be accepted in the cycle `done` is high.

## Structure
- `ram_dma_pkg`: FSM state enum, `DIR_READ`/`DIR_WRITE` constants, `RD_FIFO_DEPTH = 4`.
- Sub-module `ram_dma_fifo`: 4-deep synchronous FIFO with data and last bit, count output, same async active-low reset. The FSM, address counters and credit logic stay in `ram_dma`.

## Test plan
- RAM preloaded with 1, 0, -1 repeating; read base 0, len 9, `out_ready` = 1 → `out_data` is 00000001, 00000000, FFFFFFFF ×3, first `out_valid` in cycle 3, one word/cycle, `out_last` on the 9th word, `done` 1 cycle after it.
- Read len 8 with `out_ready` held low for 10 cycles after the first word, then toggling 1/0 → no word lost or duplicated, at most 4 words issued ahead, `out_data` stable while stalled.
- Write base 0x3FE, len 4, data A0..A3 → `ram_we` cycles at addresses 0x3FE, 0x3FF, 0x000, 0x001 with the matching data, `in_ready` low after the 4th word.
- Command with len 0 (either direction) → `done` 1 cycle later, no `ram_we`, no `out_valid`, `cmd_ready` stays high.
- Write 16 words at base 0x100, then read base 0x100, len 16 → read-back is identical.
- `rst_n` asserted asynchronously after the 3rd word of a len-9 read → outputs take reset values without waiting for a clock edge. After release, a new read len 2 returns correct data, and `done` pulses only once, for the new command.
